// File: rtl/branch_operand_hazard_unit_pkg.sv
// Shared definitions for the ID-stage early-branch operand hazard unit:
// forward-select encoding and the stall FSM state type.
package branch_operand_hazard_unit_pkg;

  localparam int DEF_REG_AW   = 5;

  // fwd_sel encoding: 0 reads the register file, k+FWD_STG_BASE forwards from stage k
  localparam int FWD_RF       = 0;
  localparam int FWD_STG_BASE = 1;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stall_state_e;

endpackage

// File: rtl/branch_operand_hazard_unit_if.sv
// Bundle between the ID stage / pipeline control and the early-branch hazard unit.
// master = pipeline side driving operand and producer info, slave = hazard unit.
interface branch_operand_hazard_unit_if
  import branch_operand_hazard_unit_pkg::*;
#(
  parameter int REG_AW    = DEF_REG_AW,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int CNT_W     = 16
) ();

  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  logic                        id_early_use;
  logic [NUM_SRC-1:0]          id_src_used;
  logic [NUM_SRC*REG_AW-1:0]   id_src_addr;
  logic                        id_branch_taken;
  logic [FWD_DEPTH-1:0]        stg_wr_en;
  logic [FWD_DEPTH*REG_AW-1:0] stg_wr_addr;
  logic [FWD_DEPTH-1:0]        stg_ready;
  logic                        perf_clr;

  logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
  logic                        stall_if_id;
  logic                        bubble_ex;
  logic                        flush_if_id;
  logic                        stall_err;
  logic [CNT_W-1:0]            stall_cycles;
  logic [CNT_W-1:0]            fwd_events;

  modport master (
    output id_early_use, id_src_used, id_src_addr, id_branch_taken,
           stg_wr_en, stg_wr_addr, stg_ready, perf_clr,
    input  fwd_sel, stall_if_id, bubble_ex, flush_if_id,
           stall_err, stall_cycles, fwd_events
  );

  modport slave (
    input  id_early_use, id_src_used, id_src_addr, id_branch_taken,
           stg_wr_en, stg_wr_addr, stg_ready, perf_clr,
    output fwd_sel, stall_if_id, bubble_ex, flush_if_id,
           stall_err, stall_cycles, fwd_events
  );

endinterface

// File: rtl/branch_operand_hazard_unit_operand_fwd_select.sv
// Per-source priority match over the downstream producer stages.
// The nearest matching stage (lowest index) wins, even when it is not ready yet.
module operand_fwd_select
  import branch_operand_hazard_unit_pkg::*;
#(
  parameter int REG_AW    = DEF_REG_AW,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        early_use,
  input  logic                        src_used,
  input  logic [REG_AW-1:0]           src_addr,
  input  logic [FWD_DEPTH-1:0]        stg_wr_en,
  input  logic [FWD_DEPTH*REG_AW-1:0] stg_wr_addr,
  input  logic [FWD_DEPTH-1:0]        stg_ready,
  output logic [SEL_W-1:0]            sel,
  output logic                        not_ready
);

  logic [FWD_DEPTH-1:0] match;
  logic                 found;

  // r0 is never forwarded: a producer writing r0 cannot match
  always_comb begin
    match = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      match[k] = early_use && src_used && stg_wr_en[k] &&
                 (stg_wr_addr[k*REG_AW +: REG_AW] != '0) &&
                 (stg_wr_addr[k*REG_AW +: REG_AW] == src_addr);
    end
  end

  always_comb begin
    sel       = SEL_W'(FWD_RF);
    not_ready = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (!found && match[k]) begin
        found     = 1'b1;
        sel       = SEL_W'(k + FWD_STG_BASE);
        not_ready = ~stg_ready[k];
      end
    end
  end

endmodule

// File: rtl/branch_operand_hazard_unit.sv
// ID-stage early-consumer operand resolution: per-source forward select, stall/bubble,
// taken-branch flush gating, stall-length watchdog and saturating perf counters.
//
// state | meaning
// RUN   | no hazard seen last cycle, cnt = 0
// STALL | IF/ID held by an unresolved operand, cnt = consecutive stall cycles (sat)
module branch_operand_hazard_unit
  import branch_operand_hazard_unit_pkg::*;
#(
  parameter int REG_AW    = DEF_REG_AW,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst,
  branch_operand_hazard_unit_if.slave bus
);

  localparam int SEL_W = $clog2(FWD_DEPTH + 1);
  localparam int CW    = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_STALL);

  logic [NUM_SRC*SEL_W-1:0] sel_raw;
  logic [NUM_SRC-1:0]       not_ready;
  logic                     hazard;
  logic                     any_fwd;

  stall_state_e             state, state_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic                     stall_err, err_nxt;
  logic [CNT_W-1:0]         stall_cycles;
  logic [CNT_W-1:0]         fwd_events;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    operand_fwd_select #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .SEL_W     (SEL_W)
    ) u_sel (
      .early_use   (bus.id_early_use),
      .src_used    (bus.id_src_used[i]),
      .src_addr    (bus.id_src_addr[i*REG_AW +: REG_AW]),
      .stg_wr_en   (bus.stg_wr_en),
      .stg_wr_addr (bus.stg_wr_addr),
      .stg_ready   (bus.stg_ready),
      .sel         (sel_raw[i*SEL_W +: SEL_W]),
      .not_ready   (not_ready[i])
    );
  end

  assign hazard = |not_ready;

  always_comb begin
    any_fwd = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_raw[i*SEL_W +: SEL_W] != SEL_W'(FWD_RF)) any_fwd = 1'b1;
    end
  end

  // Combinational outputs are held low for the whole of reset, asynchronously
  assign bus.fwd_sel      = rst ? '0 : sel_raw;
  assign bus.stall_if_id  = rst ? 1'b0 : hazard;
  assign bus.bubble_ex    = rst ? 1'b0 : hazard;
  assign bus.flush_if_id  = rst ? 1'b0 : (bus.id_branch_taken & ~hazard);
  assign bus.stall_err    = stall_err;
  assign bus.stall_cycles = stall_cycles;
  assign bus.fwd_events   = fwd_events;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      stall_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stall_err <= err_nxt;
    end
  end

  // Watchdog trips on the edge that completes the MAX_STALL-th consecutive stall cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = stall_err;
    case (state)
      RUN: begin
        if (hazard) begin
          state_nxt = STALL;
          cnt_nxt   = CW'(1);
        end
      end
      STALL: begin
        if (hazard) begin
          if (cnt != MAX_CNT) cnt_nxt = cnt + CW'(1);
        end else begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
    if (hazard && (cnt_nxt == MAX_CNT)) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (bus.perf_clr)
        stall_cycles <= '0;
      else if (hazard && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);

      if (bus.perf_clr)
        fwd_events <= '0;
      else if (!hazard && any_fwd && (fwd_events != '1))
        fwd_events <= fwd_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_operand_hazard_unit.sv
// Directed bench for branch_operand_hazard_unit (NUM_SRC=2, FWD_DEPTH=2, MAX_STALL=4, CNT_W=16).
module tb_branch_operand_hazard_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  branch_operand_hazard_unit_if bus ();

  branch_operand_hazard_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic eu, input logic [1:0] used,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] wen, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [1:0] rdy);
    bus.id_early_use = eu;
    bus.id_src_used  = used;
    bus.id_src_addr  = {s1, s0};
    bus.stg_wr_en    = wen;
    bus.stg_wr_addr  = {a1, a0};
    bus.stg_ready    = rdy;
    #1;
  endtask

  task automatic idle();
    bus.id_branch_taken = 1'b0;
    bus.perf_clr        = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00);
  endtask

  task automatic clr_perf();
    idle();
    bus.perf_clr = 1'b1;
    tick();
    bus.perf_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.perf_clr = 1'b0;
    bus.id_branch_taken = 1'b1;
    drive(1'b1, 2'b01, 5'd8, 5'd0, 2'b01, 5'd8, 5'd0, 2'b11);
    total++; if (bus.fwd_sel !== 4'b0000) begin bad++; $display("FAIL rst_fwd_sel got=%b exp=0000", bus.fwd_sel); end
    total++; if (bus.flush_if_id !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b exp=0", bus.flush_if_id); end
    total++; if (bus.stall_err !== 1'b0 || bus.stall_cycles !== 16'd0 || bus.fwd_events !== 16'd0) begin
      bad++; $display("FAIL rst_regs got err=%b sc=%0d fe=%0d exp 0/0/0", bus.stall_err, bus.stall_cycles, bus.fwd_events); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (bus.fwd_sel !== 4'b0001) begin bad++; $display("FAIL post_rst_fwd_sel got=%b exp=0001", bus.fwd_sel); end
    total++; if (bus.flush_if_id !== 1'b1) begin bad++; $display("FAIL post_rst_flush got=%b exp=1", bus.flush_if_id); end
    idle();
    clr_perf();
  endtask

  task automatic test_fwd_ex();
    drive(1'b1, 2'b01, 5'd8, 5'd0, 2'b01, 5'd8, 5'd0, 2'b11);
    total++; if (bus.fwd_sel !== 4'b0001) begin bad++; $display("FAIL ex_fwd_sel got=%b exp=0001", bus.fwd_sel); end
    total++; if (bus.stall_if_id !== 1'b0) begin bad++; $display("FAIL ex_stall got=%b exp=0", bus.stall_if_id); end
    total++; if (bus.fwd_events !== 16'd0) begin bad++; $display("FAIL ex_fe_before got=%0d exp=0", bus.fwd_events); end
    tick();
    total++; if (bus.fwd_events !== 16'd1) begin bad++; $display("FAIL ex_fe_after got=%0d exp=1", bus.fwd_events); end
    idle();
  endtask

  task automatic test_priority();
    clr_perf();
    drive(1'b1, 2'b11, 5'd8, 5'd0, 2'b11, 5'd8, 5'd8, 2'b11);
    total++; if (bus.fwd_sel !== 4'b0001) begin bad++; $display("FAIL prio_sel got=%b exp=0001", bus.fwd_sel); end
    total++; if (bus.stall_if_id !== 1'b0) begin bad++; $display("FAIL prio_stall got=%b exp=0", bus.stall_if_id); end
    drive(1'b1, 2'b11, 5'd8, 5'd0, 2'b11, 5'd8, 5'd8, 2'b10);
    total++; if (bus.stall_if_id !== 1'b1 || bus.bubble_ex !== 1'b1) begin
      bad++; $display("FAIL prio_notready got stall=%b bubble=%b exp 1/1", bus.stall_if_id, bus.bubble_ex); end
    total++; if (bus.fwd_sel !== 4'b0001) begin bad++; $display("FAIL prio_notready_sel got=%b exp=0001", bus.fwd_sel); end
    drive(1'b1, 2'b11, 5'd8, 5'd9, 2'b11, 5'd8, 5'd9, 2'b11);
    total++; if (bus.fwd_sel !== 4'b1001) begin bad++; $display("FAIL two_stage_sel got=%b exp=1001", bus.fwd_sel); end
    drive(1'b0, 2'b11, 5'd8, 5'd9, 2'b11, 5'd8, 5'd9, 2'b00);
    total++; if (bus.fwd_sel !== 4'b0000 || bus.stall_if_id !== 1'b0) begin
      bad++; $display("FAIL no_early_use got sel=%b stall=%b exp 0000/0", bus.fwd_sel, bus.stall_if_id); end
    idle();
  endtask

  task automatic test_load_use();
    clr_perf();
    drive(1'b1, 2'b10, 5'd0, 5'd9, 2'b01, 5'd9, 5'd0, 2'b00);
    total++; if (bus.stall_if_id !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", bus.stall_if_id); end
    tick();
    total++; if (bus.stall_cycles !== 16'd1) begin bad++; $display("FAIL lu_sc got=%0d exp=1", bus.stall_cycles); end
    drive(1'b1, 2'b10, 5'd0, 5'd9, 2'b10, 5'd0, 5'd9, 2'b10);
    total++; if (bus.stall_if_id !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", bus.stall_if_id); end
    total++; if (bus.fwd_sel !== 4'b1000) begin bad++; $display("FAIL lu_sel got=%b exp=1000", bus.fwd_sel); end
    tick();
    total++; if (bus.stall_cycles !== 16'd1 || bus.fwd_events !== 16'd1) begin
      bad++; $display("FAIL lu_counts got sc=%0d fe=%0d exp 1/1", bus.stall_cycles, bus.fwd_events); end
    idle();
  endtask

  task automatic test_flush_gating();
    clr_perf();
    bus.id_branch_taken = 1'b1;
    drive(1'b1, 2'b01, 5'd8, 5'd0, 2'b01, 5'd8, 5'd0, 2'b00);
    total++; if (bus.flush_if_id !== 1'b0) begin bad++; $display("FAIL flush_hazard got=%b exp=0", bus.flush_if_id); end
    tick();
    drive(1'b1, 2'b01, 5'd8, 5'd0, 2'b01, 5'd8, 5'd0, 2'b01);
    total++; if (bus.flush_if_id !== 1'b1) begin bad++; $display("FAIL flush_clear got=%b exp=1", bus.flush_if_id); end
    tick();
    idle();
    total++; if (bus.flush_if_id !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b exp=0", bus.flush_if_id); end
  endtask

  task automatic test_watchdog();
    clr_perf();
    total++; if (bus.stall_err !== 1'b0) begin bad++; $display("FAIL wd_pre got=%b exp=0", bus.stall_err); end
    drive(1'b1, 2'b01, 5'd8, 5'd0, 2'b01, 5'd8, 5'd0, 2'b00);
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++; if (bus.stall_err !== (i >= 4)) begin
        bad++; $display("FAIL wd_err_%0d got=%b exp=%b", i, bus.stall_err, (i >= 4)); end
      total++; if (bus.stall_if_id !== 1'b1) begin bad++; $display("FAIL wd_stall_%0d got=%b exp=1", i, bus.stall_if_id); end
    end
    idle();
    total++; if (bus.stall_if_id !== 1'b0) begin bad++; $display("FAIL wd_release got=%b exp=0", bus.stall_if_id); end
    tick();
    total++; if (bus.stall_err !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b exp=1", bus.stall_err); end
    total++; if (bus.stall_cycles !== 16'd6) begin bad++; $display("FAIL wd_sc got=%0d exp=6", bus.stall_cycles); end
  endtask

  task automatic test_reset_and_clear();
    bus.id_branch_taken = 1'b1;
    drive(1'b1, 2'b01, 5'd8, 5'd0, 2'b01, 5'd8, 5'd0, 2'b00);
    tick();
    #1;
    rst = 1'b1;
    #1;
    total++; if (bus.stall_if_id !== 1'b0 || bus.bubble_ex !== 1'b0) begin
      bad++; $display("FAIL mid_rst_stall got stall=%b bubble=%b exp 0/0", bus.stall_if_id, bus.bubble_ex); end
    total++; if (bus.fwd_sel !== 4'b0000 || bus.flush_if_id !== 1'b0) begin
      bad++; $display("FAIL mid_rst_comb got sel=%b flush=%b exp 0000/0", bus.fwd_sel, bus.flush_if_id); end
    total++; if (bus.stall_err !== 1'b0 || bus.stall_cycles !== 16'd0 || bus.fwd_events !== 16'd0) begin
      bad++; $display("FAIL mid_rst_regs got err=%b sc=%0d fe=%0d exp 0/0/0", bus.stall_err, bus.stall_cycles, bus.fwd_events); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.id_branch_taken = 1'b0;
    #1;
    total++; if (bus.stall_if_id !== 1'b1) begin bad++; $display("FAIL rerun_stall got=%b exp=1", bus.stall_if_id); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if (bus.stall_err !== (i == 4)) begin
        bad++; $display("FAIL rerun_err_%0d got=%b exp=%b", i, bus.stall_err, (i == 4)); end
    end
    drive(1'b1, 2'b01, 5'd8, 5'd0, 2'b01, 5'd8, 5'd0, 2'b11);
    bus.perf_clr = 1'b1;
    tick();
    bus.perf_clr = 1'b0;
    total++; if (bus.fwd_events !== 16'd0 || bus.stall_cycles !== 16'd0) begin
      bad++; $display("FAIL clr_priority got fe=%0d sc=%0d exp 0/0", bus.fwd_events, bus.stall_cycles); end
    tick();
    total++; if (bus.fwd_events !== 16'd1) begin bad++; $display("FAIL clr_then_count got=%0d exp=1", bus.fwd_events); end
    repeat (65534) @(posedge clk);
    #1;
    total++; if (bus.fwd_events !== 16'hFFFF) begin bad++; $display("FAIL fe_reach_max got=%h exp=ffff", bus.fwd_events); end
    repeat (3) tick();
    total++; if (bus.fwd_events !== 16'hFFFF) begin bad++; $display("FAIL fe_saturate got=%h exp=ffff", bus.fwd_events); end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fwd_ex();
    test_priority();
    test_load_use();
    test_flush_gating();
    test_watchdog();
    test_reset_and_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
